// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with per-register busy scoreboard.
// Two write ports (A: ALU, B: completions that also release busy), reserve
// requests for in-flight results, optional same-cycle write-to-read bypass.
// r0 reads as zero and is never busy.

// Per-read-port lookup: stored value, or forwarded write data when bypassing.
module regfile_sb_rd #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int REG_COUNT  = 32,
   parameter int BYPASS     = 1
) (
   input  logic [ADDR_WIDTH-1:0]                 i_addr,
   input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0]  i_regs,
   input  logic [REG_COUNT-1:0]                  i_busy,
   input  logic                                  i_wa_v,
   input  logic [ADDR_WIDTH-1:0]                 i_wa_addr,
   input  logic [DATA_WIDTH-1:0]                 i_wa_data,
   input  logic                                  i_wb_v,
   input  logic [ADDR_WIDTH-1:0]                 i_wb_addr,
   input  logic [DATA_WIDTH-1:0]                 i_wb_data,
   input  logic                                  i_rsv_v,
   input  logic [ADDR_WIDTH-1:0]                 i_rsv_addr,
   output logic [DATA_WIDTH-1:0]                 o_data,
   output logic                                  o_busy
);

   // Storage lookup (invalid addresses fall through to 0), then bypass override.
   // Write-valid strobes arrive pre-qualified, so a hit implies a valid address.
   always_comb begin
      o_data = '0;
      o_busy = 1'b0;
      for (int i = 1; i < REG_COUNT; i++) begin
         if (i_addr == ADDR_WIDTH'(i)) begin
            o_data = i_regs[i];
            o_busy = i_busy[i];
         end
      end
      if (BYPASS != 0) begin
         if (i_wb_v && (i_wb_addr == i_addr)) begin
            o_data = i_wb_data;
            o_busy = i_rsv_v && (i_rsv_addr == i_addr);
         end else if (i_wa_v && (i_wa_addr == i_addr)) begin
            o_data = i_wa_data;
         end
      end
   end

endmodule

module regfile_sb #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int REG_COUNT  = 32,
   parameter int RD_PORTS   = 2,
   parameter int BYPASS     = 1
) (
   input  logic                           i_CLK,
   input  logic                           i_RSTn,
   input  logic [RD_PORTS*ADDR_WIDTH-1:0] i_rd_addr,
   output logic [RD_PORTS*DATA_WIDTH-1:0] o_rd_data,
   output logic [RD_PORTS-1:0]            o_rd_busy,
   input  logic                           i_wa_en,
   input  logic [ADDR_WIDTH-1:0]          i_wa_addr,
   input  logic [DATA_WIDTH-1:0]          i_wa_data,
   input  logic                           i_wb_en,
   input  logic [ADDR_WIDTH-1:0]          i_wb_addr,
   input  logic [DATA_WIDTH-1:0]          i_wb_data,
   input  logic                           i_rsv_en,
   input  logic [ADDR_WIDTH-1:0]          i_rsv_addr,
   output logic [REG_COUNT-1:0]           o_busy_vec,
   output logic                           o_rsv_err,
   output logic                           o_wr_conflict
);

   logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
   logic [REG_COUNT-1:0]                 busy_q, busy_d;
   logic                                 rsv_err_q, rsv_err_d;
   logic                                 wr_conflict_q, wr_conflict_d;
   logic                                 wa_v, wb_v, rsv_v, rsv_hit_busy;

   function automatic logic valid_addr(input logic [ADDR_WIDTH-1:0] a);
      return (a != '0) && ({1'b0, a} < (ADDR_WIDTH+1)'(REG_COUNT));
   endfunction

   // Qualified request strobes; gating with reset keeps bypass outputs at 0 in reset.
   always_comb begin
      wa_v  = i_RSTn && i_wa_en  && valid_addr(i_wa_addr);
      wb_v  = i_RSTn && i_wb_en  && valid_addr(i_wb_addr);
      rsv_v = i_RSTn && i_rsv_en && valid_addr(i_rsv_addr);
      rsv_hit_busy = 1'b0;
      for (int i = 1; i < REG_COUNT; i++)
         if (i_rsv_addr == ADDR_WIDTH'(i)) rsv_hit_busy = busy_q[i];
   end

   // Next state: A then B (B wins data), B releases busy, a reservation re-sets it.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int i = 1; i < REG_COUNT; i++) begin
         if (wa_v && (i_wa_addr == ADDR_WIDTH'(i))) regs_d[i] = i_wa_data;
         if (wb_v && (i_wb_addr == ADDR_WIDTH'(i))) begin
            regs_d[i] = i_wb_data;
            busy_d[i] = 1'b0;
         end
         if (rsv_v && (i_rsv_addr == ADDR_WIDTH'(i))) busy_d[i] = 1'b1;
      end
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
      rsv_err_d     = rsv_v && rsv_hit_busy && !(wb_v && (i_wb_addr == i_rsv_addr));
      wr_conflict_d = wa_v && wb_v && (i_wa_addr == i_wb_addr);
   end

   // State registers, asynchronously cleared.
   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         regs_q        <= '0;
         busy_q        <= '0;
         rsv_err_q     <= 1'b0;
         wr_conflict_q <= 1'b0;
      end else begin
         regs_q        <= regs_d;
         busy_q        <= busy_d;
         rsv_err_q     <= rsv_err_d;
         wr_conflict_q <= wr_conflict_d;
      end
   end

   assign o_busy_vec    = busy_q;
   assign o_rsv_err     = rsv_err_q;
   assign o_wr_conflict = wr_conflict_q;

   regfile_sb_rd #(
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .REG_COUNT(REG_COUNT), .BYPASS(BYPASS)
   ) u_rd [RD_PORTS-1:0] (
      .i_addr     (i_rd_addr),
      .i_regs     (regs_q),
      .i_busy     (busy_q),
      .i_wa_v     (wa_v),
      .i_wa_addr  (i_wa_addr),
      .i_wa_data  (i_wa_data),
      .i_wb_v     (wb_v),
      .i_wb_addr  (i_wb_addr),
      .i_wb_data  (i_wb_data),
      .i_rsv_v    (rsv_v),
      .i_rsv_addr (i_rsv_addr),
      .o_data     (o_rd_data),
      .o_busy     (o_rd_busy)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: one bypassing and one non-bypassing instance driven with
// identical stimulus; 6-bit addresses so out-of-range address 40 is reachable.
module tb_regfile_sb;
   localparam int DW = 8, AW = 6, RC = 32, RP = 2;

   logic              clk = 1'b0, rst_n = 1'b0;
   logic [RP*AW-1:0]  rd_addr = '0;
   logic              wa_en = 0, wb_en = 0, rsv_en = 0;
   logic [AW-1:0]     wa_addr = '0, wb_addr = '0, rsv_addr = '0;
   logic [DW-1:0]     wa_data = '0, wb_data = '0;
   logic [RP*DW-1:0]  rd_data_b, rd_data_n;
   logic [RP-1:0]     rd_busy_b, rd_busy_n;
   logic [RC-1:0]     busy_b, busy_n;
   logic              err_b, err_n, conf_b, conf_n;
   int                errors = 0, checks = 0;

   always #5 clk = ~clk;

   regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC), .RD_PORTS(RP), .BYPASS(1)) dut_b (
      .i_CLK(clk), .i_RSTn(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data_b), .o_rd_busy(rd_busy_b),
      .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
      .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
      .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr),
      .o_busy_vec(busy_b), .o_rsv_err(err_b), .o_wr_conflict(conf_b));

   regfile_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC), .RD_PORTS(RP), .BYPASS(0)) dut_n (
      .i_CLK(clk), .i_RSTn(rst_n), .i_rd_addr(rd_addr), .o_rd_data(rd_data_n), .o_rd_busy(rd_busy_n),
      .i_wa_en(wa_en), .i_wa_addr(wa_addr), .i_wa_data(wa_data),
      .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
      .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr),
      .o_busy_vec(busy_n), .o_rsv_err(err_n), .o_wr_conflict(conf_n));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      wa_en = 0; wb_en = 0; rsv_en = 0;
   endtask

   task automatic rd(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
      rd_addr = {p1, p0}; #1;
   endtask

   initial begin
      // reset state
      tick(); tick();
      chk("rst_busy_b", busy_b, 0);     chk("rst_busy_n", busy_n, 0);
      chk("rst_err", {err_b, err_n, conf_b, conf_n}, 0);
      chk("rst_rd", rd_data_b, 0);
      @(negedge clk); rst_n = 1'b1; tick();

      // write A r5, r0 stays zero
      wa_en = 1; wa_addr = 5; wa_data = 8'h3C; tick(); idle();
      rd(5, 0);
      chk("r5r0_b", rd_data_b, 16'h003C); chk("r5r0_n", rd_data_n, 16'h003C);
      chk("r5r0_busy", {rd_busy_b, rd_busy_n}, 0);
      wa_en = 1; wa_addr = 0; wa_data = 8'hFF; tick(); idle();
      rd(0, 0);
      chk("r0_zero_b", rd_data_b, 0);   chk("r0_zero_n", rd_data_n, 0);

      // reserve r7, double reserve, release by B
      rsv_en = 1; rsv_addr = 7; tick(); idle();
      rd(7, 0);
      chk("rsv7_vec", busy_b, 32'h80);  chk("rsv7_rdbusy", rd_busy_b, 2'b01);
      chk("rsv7_noerr", err_b, 0);
      rsv_en = 1; rsv_addr = 7; tick(); idle(); #1;
      chk("rsv7_err_b", err_b, 1);      chk("rsv7_err_n", err_n, 1);
      chk("rsv7_still", busy_n, 32'h80);
      tick();
      chk("rsv7_err_once", {err_b, err_n}, 0);
      wb_en = 1; wb_addr = 7; wb_data = 8'hA5; rd(7, 7);
      chk("wb7_byp_b", rd_data_b, 16'hA5A5); chk("wb7_byp_busy_b", rd_busy_b, 2'b00);
      chk("wb7_nbp_n", rd_data_n, 16'h0000); chk("wb7_nbp_busy_n", rd_busy_n, 2'b11);
      tick(); idle(); #1;
      chk("wb7_vec", busy_b, 0);        chk("wb7_data_n", rd_data_n, 16'hA5A5);

      // bypass vs stored on r9 (B) and r10 (A)
      wa_en = 1; wa_addr = 9; wa_data = 8'h77; tick(); idle();
      wb_en = 1; wb_addr = 9; wb_data = 8'h11; rd(9, 9);
      chk("r9_byp", rd_data_b, 16'h1111); chk("r9_nbp", rd_data_n, 16'h7777);
      chk("r9_busy", {rd_busy_b, rd_busy_n}, 0);
      tick(); idle(); #1;
      chk("r9_after_n", rd_data_n, 16'h1111);
      wa_en = 1; wa_addr = 10; wa_data = 8'h66; rd(10, 9);
      chk("r10_byp", rd_data_b, 16'h1166); chk("r10_nbp", rd_data_n, 16'h1100);
      tick(); idle();

      // A/B same-address conflict
      wa_en = 1; wa_addr = 3; wa_data = 8'h22;
      wb_en = 1; wb_addr = 3; wb_data = 8'h44; tick(); idle(); rd(3, 10);
      chk("conf_b", conf_b, 1);         chk("conf_n", conf_n, 1);
      chk("r3_b", rd_data_b, 16'h6644);   chk("r3_n", rd_data_n, 16'h6644);
      tick();
      chk("conf_once", {conf_b, conf_n}, 0);

      // release and re-reserve r4 in the same cycle
      rsv_en = 1; rsv_addr = 4; tick(); idle();
      wb_en = 1; wb_addr = 4; wb_data = 8'h55; rsv_en = 1; rsv_addr = 4; rd(4, 4);
      chk("r4_byp", {rd_data_b, rd_busy_b}, {16'h5555, 2'b11});
      tick(); idle(); #1;
      chk("r4_vec", busy_b, 32'h10);    chk("r4_data_n", {rd_data_n, rd_busy_n}, {16'h5555, 2'b11});
      chk("r4_noerr", {err_b, err_n}, 0);

      // back-to-back rejected reserves
      rsv_en = 1; rsv_addr = 4; tick(); #1;
      chk("b2b_err1", err_b, 1);
      tick(); idle(); #1;
      chk("b2b_err2", err_n, 1);
      tick();
      chk("b2b_clear", err_b, 0);

      // out-of-range address 40: all requests ignored
      wa_en = 1; wa_addr = 40; wa_data = 8'hFF;
      wb_en = 1; wb_addr = 40; wb_data = 8'hEE;
      rsv_en = 1; rsv_addr = 40; rd(40, 4);
      chk("a40_rd", {rd_data_b, rd_busy_b}, {16'h5500, 2'b10});
      tick(); idle(); #1;
      chk("a40_vec", busy_b, 32'h10);
      chk("a40_pulse", {err_b, err_n, conf_b, conf_n}, 0);
      chk("a40_rd_after", rd_data_n, 16'h5500);

      // asynchronous reset mid-cycle with a reservation outstanding
      rsv_en = 1; rsv_addr = 12; tick(); idle(); #1;
      chk("r12_vec", busy_b, 32'h1010);
      #2; rst_n = 1'b0;
      wb_en = 1; wb_addr = 5; wb_data = 8'h99; rd(5, 3);
      chk("arst_vec_b", busy_b, 0);     chk("arst_vec_n", busy_n, 0);
      chk("arst_rd_b", {rd_data_b, rd_busy_b}, 0);
      chk("arst_rd_n", {rd_data_n, rd_busy_n}, 0);
      tick(); idle();
      @(negedge clk); rst_n = 1'b1; tick();
      rd(5, 4);
      chk("post_rst_rd", {rd_data_b, rd_data_n}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: sim did not finish, got running expected done");
      $fatal(1, "timeout");
   end
endmodule
